// File: rtl/move_scheduler.sv
// Move command sequencer: issues LFSR shuffle moves during GAME_INITIAL and
// FIFO-buffered player moves during GAMING over a valid/ready handshake.
module move_scheduler #(
  parameter int         DEPTH         = 4,
  parameter int         SHUFFLE_MOVES = 16,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic       clk_d,
  input  logic       rst,
  input  logic [1:0] game_status,
  input  logic [3:0] act_flag,
  input  logic       mv_ready,
  output logic       mv_valid,
  output logic [1:0] mv_dir,
  output logic       mv_src,
  output logic       shuffling,
  output logic       shuffle_done,
  output logic [7:0] step_count,
  output logic       overflow
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [7:0] LAST_MOVE = 8'(SHUFFLE_MOVES - 1);
  localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_SHUFFLE, S_WAIT_PLAY, S_PLAY, S_FROZEN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [7:0]  shuf_cnt_q, shuf_cnt_d;
  logic [7:0]  step_q, step_d;
  logic [1:0]  last_dir_q, last_dir_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]  mem_q [DEPTH];
  logic [1:0]  mem_d [DEPTH];
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  logic        fifo_empty, fifo_full, push, pop, flush, xfer;
  logic [1:0]  push_dir, cand, shuf_dir;

  // Fibonacci LFSR, taps 8,6,5,4, shifting left with feedback into bit 0
  function automatic logic [7:0] lfsr_step(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Never undo the previous shuffle move: an inverse candidate is turned 90 degrees
  assign cand     = lfsr_q[1:0];
  assign shuf_dir = (cand == (last_dir_q ^ 2'd1)) ? (cand ^ 2'd2) : cand;

  always_comb begin
    push_dir = 2'd3;
    if (act_flag[0])      push_dir = 2'd0;
    else if (act_flag[1]) push_dir = 2'd1;
    else if (act_flag[2]) push_dir = 2'd2;
  end

  always_comb begin
    mv_valid = 1'b0;
    mv_dir   = 2'd0;
    mv_src   = 1'b0;
    case (state_q)
      S_SHUFFLE: begin
        mv_valid = (game_status != 2'b00);
        mv_dir   = shuf_dir;
        mv_src   = 1'b1;
      end
      S_PLAY: begin
        mv_valid = !fifo_empty && (game_status != 2'b00);
        mv_dir   = fifo_empty ? 2'd0 : mem_q[rd_ptr_q[AW-1:0]];
      end
      default: ;
    endcase
  end

  assign xfer = mv_valid & mv_ready;

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    shuf_cnt_d = shuf_cnt_q;
    step_d     = step_q;
    last_dir_d = last_dir_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    flush      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (game_status == 2'b10) begin
          state_d    = S_SHUFFLE;
          shuf_cnt_d = 8'd0;
        end
      end
      S_SHUFFLE: begin
        if (xfer) begin
          last_dir_d = shuf_dir;
          shuf_cnt_d = shuf_cnt_q + 8'd1;
          lfsr_d     = lfsr_step(lfsr_q);
          if (shuf_cnt_q == LAST_MOVE) begin
            done_d  = 1'b1;
            state_d = S_WAIT_PLAY;
          end
        end
      end
      S_WAIT_PLAY: begin
        if (game_status == 2'b01) begin
          step_d  = 8'd0;
          ovf_d   = 1'b0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        pop  = xfer;
        push = |act_flag;
        if (game_status == 2'b11) begin
          state_d = S_FROZEN;
          flush   = 1'b1;
        end
      end
      S_FROZEN: begin
        flush = 1'b1;
        if (game_status == 2'b00) begin
          state_d = S_IDLE;
        end else if (game_status == 2'b10) begin
          state_d    = S_SHUFFLE;
          shuf_cnt_d = 8'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (game_status == 2'b00) begin
      state_d = S_IDLE;
      flush   = 1'b1;
      push    = 1'b0;
      pop     = 1'b0;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      step_d   = (step_q == 8'hFF) ? step_q : step_q + 8'd1;
    end
    // A simultaneous pop frees a slot, so a full FIFO still accepts the push
    if (push) begin
      if (!fifo_full || pop) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_dir;
        wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_d or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= LFSR_SEED;
      shuf_cnt_q <= 8'd0;
      step_q     <= 8'd0;
      last_dir_q <= 2'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      shuf_cnt_q <= shuf_cnt_d;
      step_q     <= step_d;
      last_dir_q <= last_dir_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  // Storage needs no reset: entries are only read between valid pointers
  always_ff @(posedge clk_d) begin
    mem_q <= mem_d;
  end

  assign shuffling    = (state_q == S_SHUFFLE);
  assign shuffle_done = done_q;
  assign step_count   = step_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed scoreboard bench for move_scheduler: shuffle sequence, stalls,
// player FIFO boundaries, freeze and asynchronous reset.
module tb_move_scheduler;

  logic       clk_d = 1'b0;
  logic       rst;
  logic [1:0] game_status;
  logic [3:0] act_flag;
  logic       mv_ready;
  logic       mv_valid;
  logic [1:0] mv_dir;
  logic       mv_src;
  logic       shuffling;
  logic       shuffle_done;
  logic [7:0] step_count;
  logic       overflow;

  move_scheduler #(.DEPTH(4), .SHUFFLE_MOVES(16), .LFSR_SEED(8'hA5)) dut (
    .clk_d(clk_d), .rst(rst), .game_status(game_status), .act_flag(act_flag),
    .mv_ready(mv_ready), .mv_valid(mv_valid), .mv_dir(mv_dir), .mv_src(mv_src),
    .shuffling(shuffling), .shuffle_done(shuffle_done), .step_count(step_count),
    .overflow(overflow)
  );

  always #5 clk_d = ~clk_d;

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;
  int n_done  = 0;
  logic [2:0] exp_q[$];
  logic [7:0] m_lfsr;
  logic [1:0] m_last;
  logic [1:0] last_sh;
  logic [1:0] held_dir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr  = 8'hA5;
    m_last  = 2'd0;
    last_sh = 2'd0;
  endtask

  // Expected shuffle moves derived from the LFSR definition
  task automatic push_shuffle(input int n);
    logic [1:0] c, d;
    for (int i = 0; i < n; i++) begin
      c = m_lfsr[1:0];
      d = (c == (m_last ^ 2'd1)) ? (c ^ 2'd2) : c;
      exp_q.push_back({1'b1, d});
      m_last = d;
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  endtask

  // Sample on the falling edge, then advance to just after the rising edge
  task automatic tick();
    logic [2:0] e;
    @(negedge clk_d);
    if (mv_valid && mv_ready) begin
      n_xfer++;
      chk("xfer_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("move_src_dir", {mv_src, mv_dir}, e);
      end
      if (mv_src) begin
        chk("no_inverse", mv_dir == (last_sh ^ 2'd1), 0);
        last_sh = mv_dir;
      end
    end
    if (shuffle_done) n_done++;
    @(posedge clk_d);
    #1;
  endtask

  task automatic run_until(input int target, input int budget);
    int g;
    g = 0;
    while (n_xfer < target && g < budget) begin
      tick();
      g++;
    end
    chk("xfer_budget", n_xfer >= target, 1);
  endtask

  initial begin
    rst = 1'b0; game_status = 2'b00; act_flag = 4'b0; mv_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", mv_valid, 0);
    chk("rst_outs", {mv_dir, mv_src, shuffling, shuffle_done, step_count, overflow}, 0);
    @(posedge clk_d); #1;
    rst = 1'b1;

    // Full shuffle with the datapath always ready
    game_status = 2'b10; mv_ready = 1'b1;
    push_shuffle(16);
    n_xfer = 0; n_done = 0;
    run_until(16, 60);
    tick(); tick();
    chk("t1_xfers", n_xfer, 16);
    chk("t1_done_pulses", n_done, 1);
    chk("t1_shuffling", shuffling, 0);
    chk("t1_valid", mv_valid, 0);
    chk("t1_queue", exp_q.size(), 0);

    // Asynchronous reset mid-shuffle with a pending move
    rst = 1'b0; #3; rst = 1'b1;
    game_status = 2'b10;
    model_reset(); push_shuffle(16);
    n_xfer = 0;
    run_until(5, 20);
    chk("t6_valid_before", mv_valid, 1);
    #3; rst = 1'b0; #1;
    chk("t6_valid_async", mv_valid, 0);
    chk("t6_outs_async", {mv_dir, mv_src, shuffling, shuffle_done, step_count, overflow}, 0);
    exp_q.delete();
    @(posedge clk_d); #1;
    rst = 1'b1;

    // Restart from seed with a five-cycle stall mid-run
    model_reset(); push_shuffle(16);
    n_xfer = 0; n_done = 0;
    run_until(6, 20);
    mv_ready = 1'b0;
    held_dir = mv_dir;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_stall_valid", mv_valid, 1);
      chk("t2_stall_dir", mv_dir, held_dir);
    end
    mv_ready = 1'b1;
    run_until(16, 40);
    tick(); tick();
    chk("t2_xfers", n_xfer, 16);
    chk("t2_done_pulses", n_done, 1);
    chk("t2_queue", exp_q.size(), 0);

    // Player FIFO fills, fifth move overflows, then drains in order
    mv_ready = 1'b0; game_status = 2'b01;
    tick();
    chk("t3_step_clr", step_count, 0);
    chk("t3_ovf_clr", overflow, 0);
    act_flag = 4'b0001; tick();
    chk("t3_latency_valid", mv_valid, 1);
    chk("t3_latency_dir", mv_dir, 0);
    act_flag = 4'b0010; tick();
    act_flag = 4'b0100; tick();
    act_flag = 4'b1000; tick();
    chk("t3_no_ovf_yet", overflow, 0);
    act_flag = 4'b0001; tick();
    act_flag = 4'b0000; tick();
    chk("t3_overflow", overflow, 1);
    chk("t3_head_dir", mv_dir, 0);
    for (int d = 0; d < 4; d++) exp_q.push_back({1'b0, 2'(d)});
    mv_ready = 1'b1; n_xfer = 0;
    run_until(4, 10);
    tick();
    chk("t3_xfers", n_xfer, 4);
    chk("t3_step_count", step_count, 4);
    chk("t3_empty", mv_valid, 0);

    // Several flags in one cycle enqueue only the lowest index
    mv_ready = 1'b0;
    act_flag = 4'b0110; tick();
    act_flag = 4'b0000; tick();
    chk("t4_valid", mv_valid, 1);
    chk("t4_dir", mv_dir, 1);
    exp_q.push_back({1'b0, 2'd1});
    mv_ready = 1'b1; n_xfer = 0;
    tick(); tick(); tick();
    chk("t4_xfers", n_xfer, 1);
    chk("t4_step_count", step_count, 5);

    // Freeze with three queued moves, then return to idle
    mv_ready = 1'b0;
    act_flag = 4'b0001; tick();
    act_flag = 4'b0010; tick();
    act_flag = 4'b0100; tick();
    act_flag = 4'b0000;
    chk("t5_queued", mv_valid, 1);
    game_status = 2'b11; tick();
    chk("t5_frozen_valid", mv_valid, 0);
    chk("t5_step_held", step_count, 5);
    act_flag = 4'b0001; tick();
    act_flag = 4'b0000;
    chk("t5_frozen_ignore", mv_valid, 0);
    game_status = 2'b00; tick();
    chk("t5_idle_valid", mv_valid, 0);
    chk("t5_idle_step", step_count, 5);
    act_flag = 4'b0001; tick();
    act_flag = 4'b0000;
    chk("t5_idle_ignore", mv_valid, 0);
    game_status = 2'b10; tick();
    chk("t5_reshuffle", shuffling, 1);
    chk("t5_no_xfer", n_xfer, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
